// File: rtl/wt_dcache_shct_ctrl.sv
// Signature history counter table (SHCT) controller.
// The single-ported, flop-based counter table is shared by prediction
// lookups and queued training updates. It also sequences a whole-table
// flush back to INIT_CNT.
module wt_dcache_shct_ctrl #(
  parameter int unsigned SIG_WIDTH        = 14,
  parameter int unsigned IDX_WIDTH        = 10,
  parameter int unsigned CNT_WIDTH        = 3,
  parameter int unsigned INIT_CNT         = 1,
  parameter int unsigned TRAIN_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  input  logic                 train_vld_i,
  input  logic                 train_inc_i,
  input  logic [SIG_WIDTH-1:0] train_sig_i,
  output logic                 train_rdy_o,
  input  logic                 lookup_req_i,
  input  logic [SIG_WIDTH-1:0] lookup_sig_i,
  output logic                 lookup_ack_o,
  output logic                 lookup_vld_o,
  output logic [CNT_WIDTH-1:0] lookup_cnt_o,
  output logic                 lookup_dist_o,
  output logic                 busy_o
);

  localparam int unsigned Entries = 2 ** IDX_WIDTH;
  localparam int unsigned PtrW    = (TRAIN_FIFO_DEPTH > 1) ? $clog2(TRAIN_FIFO_DEPTH) : 1;
  localparam int unsigned FcntW   = $clog2(TRAIN_FIFO_DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] InitCnt  = CNT_WIDTH'(INIT_CNT);
  localparam logic [CNT_WIDTH-1:0] MaxCnt   = '1;
  localparam logic [IDX_WIDTH-1:0] LastIdx  = '1;
  localparam logic [FcntW-1:0]     FifoFull = FcntW'(TRAIN_FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] tbl_q [Entries];

  logic [IDX_WIDTH-1:0]        fifo_idx_q [TRAIN_FIFO_DEPTH];
  logic [TRAIN_FIFO_DEPTH-1:0] fifo_inc_q;
  logic [PtrW-1:0]             wptr_q, rptr_q;
  logic [FcntW-1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                        fifo_full, fifo_empty;

  logic [IDX_WIDTH-1:0] flush_idx_q, flush_idx_d;
  logic                 flush_done_q;

  logic                 lookup_vld_q, lookup_dist_q;
  logic [CNT_WIDTH-1:0] lookup_cnt_q;

  logic                 push, pop, fifo_clr, flush_we, flush_last;
  logic [IDX_WIDTH-1:0] head_idx, lk_idx, tbl_widx;
  logic [CNT_WIDTH-1:0] head_cnt, train_new, lk_cnt, tbl_wdata;
  logic                 head_inc, tbl_we;

  // Only the low signature bits index the table; the rest alias.
  if (SIG_WIDTH > IDX_WIDTH) begin : g_unused_sig
    logic unused_sig;
    assign unused_sig = ^{train_sig_i[SIG_WIDTH-1:IDX_WIDTH], lookup_sig_i[SIG_WIDTH-1:IDX_WIDTH]};
  end

  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign train_rdy_o = (state_q == StIdle) && !fifo_full;
  assign busy_o      = (state_q == StFlush) || !fifo_empty;
  assign push        = train_vld_i && train_rdy_o;

  assign head_idx = fifo_idx_q[rptr_q];
  assign head_inc = fifo_inc_q[rptr_q];
  assign head_cnt = tbl_q[head_idx];
  assign lk_idx   = lookup_sig_i[IDX_WIDTH-1:0];
  assign lk_cnt   = tbl_q[lk_idx];

  // Arbitration and flush sequencing; flush beats lookup, lookup beats a pop unless full.
  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    lookup_ack_o = 1'b0;
    pop          = 1'b0;
    fifo_clr     = 1'b0;
    flush_we     = 1'b0;
    flush_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d     = StFlush;
          flush_idx_d = '0;
          fifo_clr    = 1'b1;
        end else if (lookup_req_i && !fifo_full) begin
          lookup_ack_o = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      StFlush: begin
        flush_we    = 1'b1;
        flush_idx_d = flush_idx_q + IDX_WIDTH'(1);
        if (flush_idx_q == LastIdx) begin
          flush_last = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating update of the head counter and the single table write port.
  always_comb begin
    train_new = head_cnt;
    if (head_inc) begin
      if (head_cnt != MaxCnt) train_new = head_cnt + CNT_WIDTH'(1);
    end else begin
      if (head_cnt != '0) train_new = head_cnt - CNT_WIDTH'(1);
    end
    tbl_we    = flush_we || pop;
    tbl_widx  = flush_we ? flush_idx_q : head_idx;
    tbl_wdata = flush_we ? InitCnt : train_new;
  end

  // FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + FcntW'(1);
    if (pop && !push) fifo_cnt_d = fifo_cnt_q - FcntW'(1);
  end

  // Control state: FSM, flush index, lookup result and flush-done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      flush_idx_q   <= '0;
      flush_done_q  <= 1'b0;
      lookup_vld_q  <= 1'b0;
      lookup_cnt_q  <= '0;
      lookup_dist_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      flush_done_q <= flush_last;
      lookup_vld_q <= lookup_ack_o;
      if (lookup_ack_o) begin
        lookup_cnt_q  <= lk_cnt;
        lookup_dist_q <= (lk_cnt == '0);
      end
    end
  end

  // Training FIFO storage and pointers; entering flush discards the contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(TRAIN_FIFO_DEPTH); i++) fifo_idx_q[i] <= '0;
      fifo_inc_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else if (fifo_clr) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_idx_q[wptr_q] <= train_sig_i[IDX_WIDTH-1:0];
        fifo_inc_q[wptr_q] <= train_inc_i;
        wptr_q             <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Counter table; one write per cycle from either a train or the flush walk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) tbl_q[i] <= InitCnt;
    end else if (tbl_we) begin
      tbl_q[tbl_widx] <= tbl_wdata;
    end
  end

  assign lookup_vld_o  = lookup_vld_q;
  assign lookup_cnt_o  = lookup_cnt_q;
  assign lookup_dist_o = lookup_dist_q;
  assign flush_done_o  = flush_done_q;

endmodule

// File: tb/tb_wt_dcache_shct_ctrl.sv
// Scoreboard bench for wt_dcache_shct_ctrl: a queue/array reference model
// predicts handshakes and lookup results; a monitor compares returned values.
module tb_wt_dcache_shct_ctrl;

  localparam int NumEnt = 1024;
  localparam int Depth  = 4;
  localparam int MaxC   = 7;
  localparam int InitC  = 1;

  logic        clk, rst_n;
  logic        flush_i, flush_done;
  logic        train_vld, train_inc, train_rdy;
  logic [13:0] train_sig, lookup_sig;
  logic        lookup_req, lookup_ack, lookup_vld, lookup_dist, busy;
  logic [2:0]  lookup_cnt;

  int errors = 0;
  int checks = 0;

  wt_dcache_shct_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush_i),
    .flush_done_o (flush_done),
    .train_vld_i  (train_vld),
    .train_inc_i  (train_inc),
    .train_sig_i  (train_sig),
    .train_rdy_o  (train_rdy),
    .lookup_req_i (lookup_req),
    .lookup_sig_i (lookup_sig),
    .lookup_ack_o (lookup_ack),
    .lookup_vld_o (lookup_vld),
    .lookup_cnt_o (lookup_cnt),
    .lookup_dist_o(lookup_dist),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    bit inc;
  } train_t;

  train_t mq[$];
  int     mtbl[NumEnt];
  int     sb[$];
  bit     m_flushing, pend_vld, pend_done;
  int     m_fcnt;
  bit     e_full, e_ack, e_rdy, e_busy;
  train_t t;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_vld", lookup_vld, 0);
      check("rst_cnt", lookup_cnt, 0);
      check("rst_dist", lookup_dist, 0);
      check("rst_done", flush_done, 0);
      check("rst_rdy", train_rdy, 1);
      check("rst_busy", busy, 0);
      foreach (mtbl[i]) mtbl[i] = InitC;
      mq.delete();
      sb.delete();
      m_flushing = 0;
      m_fcnt     = 0;
      pend_vld   = 0;
      pend_done  = 0;
    end else begin
      check("lookup_vld", lookup_vld, pend_vld);
      check("flush_done", flush_done, pend_done);
      e_full = (mq.size() == Depth);
      if (m_flushing) begin
        e_ack  = 0;
        e_rdy  = 0;
        e_busy = 1;
      end else begin
        e_rdy  = !e_full;
        e_busy = (mq.size() != 0);
        e_ack  = lookup_req && !e_full && !flush_i;
      end
      check("lookup_ack", lookup_ack, e_ack);
      check("train_rdy", train_rdy, e_rdy);
      check("busy", busy, e_busy);

      pend_vld  = e_ack;
      pend_done = 0;
      if (e_ack) sb.push_back(mtbl[int'(lookup_sig[9:0])]);
      if (m_flushing) begin
        m_fcnt++;
        if (m_fcnt == NumEnt) begin
          m_flushing = 0;
          foreach (mtbl[i]) mtbl[i] = InitC;
          pend_done = 1;
        end
      end else if (flush_i) begin
        mq.delete();
        m_flushing = 1;
        m_fcnt     = 0;
      end else begin
        if (!e_ack && mq.size() != 0) begin
          t = mq.pop_front();
          if (t.inc) mtbl[t.idx] = (mtbl[t.idx] == MaxC) ? MaxC : mtbl[t.idx] + 1;
          else       mtbl[t.idx] = (mtbl[t.idx] == 0) ? 0 : mtbl[t.idx] - 1;
        end
        if (train_vld && e_rdy) begin
          t.idx = int'(train_sig[9:0]);
          t.inc = train_inc;
          mq.push_back(t);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int exp_cnt;
  always @(negedge clk) begin
    if (rst_n && lookup_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lookup_unexpected: vld=1 with no lookup outstanding at %0t", $time);
      end else begin
        exp_cnt = sb.pop_front();
        check("lookup_cnt", lookup_cnt, exp_cnt);
        check("lookup_dist", lookup_dist, exp_cnt == 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int sig);
    bit got = 0;
    lookup_sig = sig[13:0];
    lookup_req = 1'b1;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      got = lookup_ack;
      tick();
    end
    lookup_req = 1'b0;
    if (!got) timeout("lookup_ack");
  endtask

  task automatic push_train(input int sig, input bit inc);
    bit got = 0;
    train_sig = sig[13:0];
    train_inc = inc;
    train_vld = 1'b1;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      got = train_rdy;
      tick();
    end
    train_vld = 1'b0;
    if (!got) timeout("train_rdy");
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      got = !busy;
      tick();
    end
    if (!got) timeout("busy_clear");
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 1200 && !got; n++) begin
      @(negedge clk);
      got = flush_done;
      tick();
    end
    if (!got) timeout("flush_done");
  endtask

  int sigs[5];
  initial begin
    sigs[0] = 'h0005; sigs[1] = 'h0405; sigs[2] = 'h03ff; sigs[3] = 'h0100; sigs[4] = 'h2005;
    flush_i = 0; train_vld = 0; train_inc = 0; train_sig = 0;
    lookup_req = 0; lookup_sig = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: lookup straight after reset
    do_lookup('h0005);
    tick();
    // 2: decrement saturates at zero
    repeat (3) push_train('h0005, 1'b0);
    wait_idle();
    do_lookup('h0005);
    // 3: increment saturates at max, neighbour untouched
    repeat (10) push_train('h03ff, 1'b1);
    wait_idle();
    do_lookup('h03ff);
    do_lookup('h03fe);
    // 4: aliasing signature shares the index
    repeat (2) push_train('h0405, 1'b1);
    wait_idle();
    do_lookup('h0005);
    // 5: continuous lookup pressure while training back-to-back
    lookup_sig = 14'h0100;
    lookup_req = 1'b1;
    repeat (5) push_train('h0100, 1'b1);
    lookup_req = 1'b0;
    wait_idle();
    do_lookup('h0100);

    // random mix
    for (int n = 0; n < 800; n++) begin
      train_vld  = ($urandom_range(0, 1) == 1);
      train_inc  = ($urandom_range(0, 2) != 0);
      train_sig  = 14'(sigs[$urandom_range(0, 4)]);
      lookup_req = ($urandom_range(0, 2) == 0);
      lookup_sig = 14'(sigs[$urandom_range(0, 4)]);
      flush_i    = ($urandom_range(0, 599) == 0);
      tick();
    end
    train_vld = 0; lookup_req = 0; flush_i = 0;
    repeat (1100) begin
      if (!busy) break;
      tick();
    end
    wait_idle();

    // 6: flush with two trains queued
    lookup_sig = 14'h0005;
    lookup_req = 1'b1;
    push_train('h0005, 1'b1);
    push_train('h03ff, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    lookup_req = 1'b0;
    wait_done();
    do_lookup('h0005);
    do_lookup('h03ff);

    // 6b: reset partway through a flush
    repeat (3) push_train('h03ff, 1'b1);
    wait_idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (499) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (1100) tick();
    do_lookup('h0005);
    do_lookup('h03ff);
    do_lookup('h0100);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
